seg_scan_n: RTL and testbench

SEG_SCAN_N -- requirements
Module: seg_scan_n

---
 rtl/seg_scan_n.sv | 122 ++++++++++++
 tb/tb_seg_scan_n.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_n.sv
// rtl/seg_scan_n.sv - multiplexed N-digit hex seven-segment scanner with shadow register
// Optional leading-zero blanking is built only when SEG_LZB_EN is defined.
module seg_scan_n #(
  parameter int N_DIG   = 8,
  parameter int CLK_DIV = 25000,
  parameter int SW      = $clog2(N_DIG)
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               load,
  input  logic [4*N_DIG-1:0] din,
  input  logic               blank,
  output logic [N_DIG-1:0]   DIG,
  output logic [6:0]         SEG,
  output logic [SW-1:0]      SEL,
  output logic               clk_1khz,
  output logic [3:0]         data
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0]      div_q, div_d;
  logic [SW-1:0]      sel_q, sel_d;
  logic               clk_q, clk_d;
  logic [4*N_DIG-1:0] shadow_q, shadow_d;
  logic [3:0]         data_q, data_d;
  logic [N_DIG-1:0]   dig_q, dig_d;
  logic [6:0]         seg_q, seg_d;
  logic               tick;
  logic               off;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Outputs are computed from next-state SEL and shadow so they move on the same edge.
  always_comb begin
    tick     = (div_q == DW'(CLK_DIV - 1));
    div_d    = tick ? '0 : div_q + 1'b1;
    sel_d    = sel_q;
    if (tick) begin
      sel_d = (sel_q == SW'(N_DIG - 1)) ? '0 : sel_q + 1'b1;
    end
    clk_d    = clk_q ^ tick;
    shadow_d = load ? din : shadow_q;
    data_d   = '0;
    for (int k = 0; k < N_DIG; k++) begin
      if (sel_d == SW'(k)) data_d = shadow_d[4*k +: 4];
    end
  end

`ifdef SEG_LZB_EN
  logic lz_hit;
  logic lz_run;

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    lz_hit = 1'b0;
    lz_run = 1'b1;
    for (int k = N_DIG - 1; k >= 1; k--) begin
      lz_run = lz_run & (shadow_d[4*k +: 4] == 4'h0);
      if (sel_d == SW'(k)) lz_hit = lz_run;
    end
  end

  assign off = blank | lz_hit;
`else
  assign off = blank;
`endif

  always_comb begin
    dig_d = '1;
    for (int k = 0; k < N_DIG; k++) begin
      if (!off && (sel_d == SW'(k))) dig_d[k] = 1'b0;
    end
    seg_d = off ? 7'b1111111 : hex7(data_d);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      div_q    <= '0;
      sel_q    <= '0;
      clk_q    <= 1'b0;
      shadow_q <= '0;
      data_q   <= '0;
      dig_q    <= {{(N_DIG-1){1'b1}}, 1'b0};
      seg_q    <= 7'b1000000;
    end else begin
      div_q    <= div_d;
      sel_q    <= sel_d;
      clk_q    <= clk_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
    end
  end

  assign DIG      = dig_q;
  assign SEG      = seg_q;
  assign SEL      = sel_q;
  assign clk_1khz = clk_q;
  assign data     = data_q;

endmodule

// File: tb/tb_seg_scan_n.sv
// tb/tb_seg_scan_n.sv - table-driven bench for seg_scan_n (N_DIG=4, CLK_DIV=4)
// Expectations for leading-zero rows follow SEG_LZB_EN when it is defined.
module tb_seg_scan_n;

`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] SA   = 7'b0001000;
  localparam logic [6:0] SOFF = 7'b1111111;

  logic        clk_in = 1'b0;
  logic        rst, load, blank;
  logic [15:0] din;
  logic [3:0]  DIG;
  logic [6:0]  SEG;
  logic [1:0]  SEL;
  logic        clk_1khz;
  logic [3:0]  data;

  int passed = 0;
  int total  = 0;

  seg_scan_n #(.N_DIG(4), .CLK_DIV(4)) dut (
    .clk_in(clk_in), .rst(rst), .load(load), .din(din), .blank(blank),
    .DIG(DIG), .SEG(SEG), .SEL(SEL), .clk_1khz(clk_1khz), .data(data)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst, load, blank;
    logic [15:0] din;
    logic [3:0]  dig;
    logic [6:0]  seg;
    logic [1:0]  sel;
    logic        ck;
    logic [3:0]  dat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic l, input logic [15:0] d, input logic b,
                              input logic [3:0] dg, input logic [6:0] sg, input logic [1:0] sl,
                              input logic ck, input logic [3:0] dt);
    vec_t v;
    v.rst = r; v.load = l; v.din = d; v.blank = b;
    v.dig = dg; v.seg = sg; v.sel = sl; v.ck = ck; v.dat = dt;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s row %0d: got %h expected %h", name, idx, got, exp);
    else passed++;
  endtask

  initial begin
    int n;
    int per;
    int sel_bad;
    logic prev;

    rst = 1'b1; load = 1'b0; blank = 1'b0; din = '0;

    add(1, 0, 16'h0000, 0, 4'b1110, S0, 0, 0, 4'h0);
    add(1, 0, 16'h0000, 0, 4'b1110, S0, 0, 0, 4'h0);
    add(0, 1, 16'h3A71, 0, 4'b1110, S1, 0, 0, 4'h1);
    repeat (2) add(0, 0, 16'h3A71, 0, 4'b1110, S1, 0, 0, 4'h1);
    repeat (4) add(0, 0, 16'h3A71, 0, 4'b1101, S7, 1, 1, 4'h7);
    repeat (4) add(0, 0, 16'h3A71, 0, 4'b1011, SA, 2, 0, 4'hA);
    repeat (2) add(0, 0, 16'h3A71, 0, 4'b0111, S3, 3, 1, 4'h3);
    repeat (2) add(0, 0, 16'hFFFF, 0, 4'b0111, S3, 3, 1, 4'h3);
    add(0, 1, 16'h0008, 0, 4'b1110, S8, 0, 0, 4'h8);
    repeat (3) add(0, 0, 16'h0008, 1, 4'b1111, SOFF, 0, 0, 4'h8);
    repeat (4) add(0, 0, 16'h0008, 1, 4'b1111, SOFF, 1, 1, 4'h0);
    add(0, 0, 16'h0008, 1, 4'b1111, SOFF, 2, 0, 4'h0);
    repeat (2) add(0, 0, 16'h0008, 0, 4'b1011, S0, 2, 0, 4'h0);
    add(1, 1, 16'h1234, 1, 4'b1110, S0, 0, 0, 4'h0);
    repeat (3) add(0, 0, 16'hFFFF, 0, 4'b1110, S0, 0, 0, 4'h0);
    add(0, 0, 16'hFFFF, 0, 4'b1101, S0, 1, 1, 4'h0);
    add(0, 1, 16'h0050, 0, 4'b1101, S5, 1, 1, 4'h5);
    repeat (2) add(0, 0, 16'h0050, 0, 4'b1101, S5, 1, 1, 4'h5);
    repeat (4) add(0, 0, 16'h0050, 0, LZB ? 4'b1111 : 4'b1011, LZB ? SOFF : S0, 2, 0, 4'h0);
    repeat (4) add(0, 0, 16'h0050, 0, LZB ? 4'b1111 : 4'b0111, LZB ? SOFF : S0, 3, 1, 4'h0);
    add(0, 0, 16'h0050, 0, 4'b1110, S0, 0, 0, 4'h0);
    add(0, 1, 16'h0000, 0, 4'b1110, S0, 0, 0, 4'h0);
    repeat (2) add(0, 0, 16'h0000, 0, 4'b1110, S0, 0, 0, 4'h0);
    add(0, 0, 16'h0000, 0, LZB ? 4'b1111 : 4'b1101, LZB ? SOFF : S0, 1, 1, 4'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; load = vecs[i].load; din = vecs[i].din; blank = vecs[i].blank;
      @(posedge clk_in); #1;
      check("DIG", i, 16'(DIG), 16'(vecs[i].dig));
      check("SEG", i, 16'(SEG), 16'(vecs[i].seg));
      check("SEL", i, 16'(SEL), 16'(vecs[i].sel));
      check("clk_1khz", i, 16'(clk_1khz), 16'(vecs[i].ck));
      check("data", i, 16'(data), 16'(vecs[i].dat));
    end

    // Reset mid-scan, then time the first tick after release.
    rst = 1'b1; load = 1'b0; blank = 1'b0; din = 16'h0000;
    @(posedge clk_in); #1;
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_in); #1;
      n++;
      if (SEL == 2'd1) break;
    end
    check("tick_latency", 0, 16'(n), 16'd4);
    check("clk_1khz_first", 0, 16'(clk_1khz), 16'd1);

    // clk_1khz period in clk_in cycles, SEL range watched meanwhile.
    per = 0;
    sel_bad = 0;
    prev = clk_1khz;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_in); #1;
      per++;
      if (SEL > 2'd3) sel_bad++;
      if (!prev && clk_1khz) break;
      prev = clk_1khz;
    end
    check("clk_1khz_period", 0, 16'(per), 16'd8);
    check("sel_range", 0, 16'(sel_bad), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
